// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared types and helpers for the branch target predictor
//
// Purpose: the BTB entry record, the weak-taken counter init value and
//          width-generic saturating counter helpers.
// Ports:   none (package).
package bpu_pkg;

  // Widest PC and counter the entry record can carry. Modules store their
  // configured widths zero-extended into these fields.
  localparam int BPU_MAX_PC_W  = 32;
  localparam int BPU_MAX_CTR_W = 8;

  typedef struct packed {
    logic                     valid;
    logic [BPU_MAX_PC_W-1:0]  tag;
    logic [BPU_MAX_PC_W-1:0]  target;
    logic [BPU_MAX_CTR_W-1:0] ctr;
  } bpu_entry_t;

  // Weak-taken: MSB of a w-bit counter set, all lower bits clear.
  function automatic logic [31:0] ctr_weak_taken(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  // Increment a w-bit value, holding at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] top;
    top = 32'hFFFF_FFFF >> (32 - w);
    return (v >= top) ? top : v + 32'd1;
  endfunction

  // Decrement a value, holding at zero.
  function automatic logic [31:0] sat_dec(input logic [31:0] v, input int unsigned w);
    logic [31:0] top;
    top = 32'hFFFF_FFFF >> (32 - w);
    return (v == 32'd0) ? 32'd0 : ((v > top) ? top : v - 32'd1);
  endfunction

endpackage

// File: rtl/bpu_btb_entry.sv
// rtl/bpu_btb_entry.sv - one BTB entry: registers, tag compares, counter update
//
// Purpose: holds valid/tag/target/ctr for a single branch and applies
//          allocation or training on the rising edge.
// Ports:   clk, rst_n            - clock, async active-low reset
//          lkp_pc                - lookup PC; lkp_match/lkp_taken/lkp_target out
//          upd_valid/upd_pc/upd_target/upd_taken - resolved branch
//          alloc                 - overwrite this entry with the resolved branch
//          upd_hit               - entry is valid and tagged with upd_pc
module bpu_btb_entry
  import bpu_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int CTR_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] lkp_pc,
  output logic            lkp_match,
  output logic            lkp_taken,
  output logic [PC_W-1:0] lkp_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_taken,
  input  logic            alloc,
  output logic            upd_hit
);

  localparam logic [BPU_MAX_CTR_W-1:0] CTR_INIT = BPU_MAX_CTR_W'(ctr_weak_taken(CTR_W));

  bpu_entry_t ent_q;
  logic [BPU_MAX_CTR_W-1:0] ctr_up;
  logic [BPU_MAX_CTR_W-1:0] ctr_dn;

  assign lkp_match  = ent_q.valid && (ent_q.tag == BPU_MAX_PC_W'(lkp_pc));
  assign lkp_taken  = ent_q.ctr[CTR_W-1];
  assign lkp_target = PC_W'(ent_q.target);
  assign upd_hit    = ent_q.valid && (ent_q.tag == BPU_MAX_PC_W'(upd_pc));

  assign ctr_up = BPU_MAX_CTR_W'(sat_inc(32'(ent_q.ctr), CTR_W));
  assign ctr_dn = BPU_MAX_CTR_W'(sat_dec(32'(ent_q.ctr), CTR_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q <= '0;
    end else if (alloc) begin
      ent_q.valid  <= 1'b1;
      ent_q.tag    <= BPU_MAX_PC_W'(upd_pc);
      ent_q.target <= BPU_MAX_PC_W'(upd_target);
      ent_q.ctr    <= CTR_INIT;
    end else if (upd_valid && upd_hit) begin
      if (upd_taken) begin
        ent_q.ctr    <= ctr_up;
        ent_q.target <= BPU_MAX_PC_W'(upd_target);
      end else begin
        ent_q.ctr    <= ctr_dn;
      end
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - BTB with direction counters and mispredict flush
//
// Purpose: predicts direction/target for the IF/ID branch, trains on EX/MEM
//          resolution, and emits a registered flush/redirect on mispredict.
// Ports:   clk, rst_n                    - clock, async active-low reset
//          lkp_valid, lkp_pc             - lookup request
//          pred_hit/pred_taken/pred_target - combinational prediction
//          upd_*                         - resolved branch and its carried prediction
//          flush, redirect_pc            - one-cycle squash and correct fetch PC
//          mispred_cnt                   - saturating mispredict statistic
module branch_target_predictor
  import bpu_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int PC_W    = 16,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lkp_valid,
  input  logic [PC_W-1:0]   lkp_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic [PC_W-1:0]   upd_pc_next,
  input  logic [PC_W-1:0]   upd_target,
  input  logic              upd_taken,
  input  logic              upd_pred_taken,
  input  logic [PC_W-1:0]   upd_pred_target,
  output logic              flush,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int VP_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] lkp_match;
  logic [ENTRIES-1:0] lkp_taken;
  logic [PC_W-1:0]    lkp_target [ENTRIES];
  logic [ENTRIES-1:0] upd_hit;
  logic [VP_W-1:0]    vp_q;
  logic               alloc_en;
  logic               mispredict;

  // Allocation only on a taken miss, so a PC never occupies two entries.
  assign alloc_en = upd_valid && upd_taken && (upd_hit == '0);

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    bpu_btb_entry #(
      .PC_W  (PC_W),
      .CTR_W (CTR_W)
    ) u_entry (
      .clk        (clk),
      .rst_n      (rst_n),
      .lkp_pc     (lkp_pc),
      .lkp_match  (lkp_match[i]),
      .lkp_taken  (lkp_taken[i]),
      .lkp_target (lkp_target[i]),
      .upd_valid  (upd_valid),
      .upd_pc     (upd_pc),
      .upd_target (upd_target),
      .upd_taken  (upd_taken),
      .alloc      (alloc_en && (vp_q == VP_W'(i))),
      .upd_hit    (upd_hit[i])
    );
  end

  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    pred_hit    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (lkp_valid && lkp_match[i]) begin
        pred_hit    = 1'b1;
        pred_taken  = lkp_taken[i];
        pred_target = lkp_target[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vp_q <= '0;
    end else if (alloc_en) begin
      vp_q <= (vp_q == VP_W'(ENTRIES - 1)) ? '0 : vp_q + 1'b1;
    end
  end

  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_target)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
      mispred_cnt <= '0;
    end else begin
      flush <= mispredict;
      if (mispredict) begin
        redirect_pc <= upd_taken ? upd_target : upd_pc_next;
        mispred_cnt <= STAT_W'(sat_inc(32'(mispred_cnt), STAT_W));
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - directed plus randomized bench for branch_target_predictor
module tb_branch_target_predictor;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lkp_valid = 1'b0;
  logic [15:0] lkp_pc = '0;
  logic        pred_hit;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_pc = '0;
  logic [15:0] upd_pc_next = '0;
  logic [15:0] upd_target = '0;
  logic        upd_taken = 1'b0;
  logic        upd_pred_taken = 1'b0;
  logic [15:0] upd_pred_target = '0;
  logic        flush;
  logic [15:0] redirect_pc;
  logic [15:0] mispred_cnt;

  int errors = 0;
  int checks = 0;

  // Reference state: plain integers, indexed table, modulo victim pointer.
  bit m_valid [N];
  int m_tag   [N];
  int m_tgt   [N];
  int m_ctr   [N];
  int m_vp;
  int m_flush;
  int m_redir;
  int m_cnt;

  always #5 clk = ~clk;

  branch_target_predictor #(
    .ENTRIES (N),
    .PC_W    (16),
    .CTR_W   (2),
    .STAT_W  (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .lkp_valid       (lkp_valid),
    .lkp_pc          (lkp_pc),
    .pred_hit        (pred_hit),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_pc_next     (upd_pc_next),
    .upd_target      (upd_target),
    .upd_taken       (upd_taken),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .flush           (flush),
    .redirect_pc     (redirect_pc),
    .mispred_cnt     (mispred_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_find(input int pc);
    for (int i = 0; i < N; i++)
      if (m_valid[i] && m_tag[i] == pc) return i;
    return -1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
    end
    m_vp = 0; m_flush = 0; m_redir = 0; m_cnt = 0;
  endtask

  task automatic check_lookup(input string tag);
    int h;
    h = lkp_valid ? m_find(int'(lkp_pc)) : -1;
    check({tag, ".hit"},    32'(pred_hit),    (h >= 0) ? 32'd1 : 32'd0);
    check({tag, ".taken"},  32'(pred_taken),  (h >= 0 && m_ctr[h] >= 2) ? 32'd1 : 32'd0);
    check({tag, ".target"}, 32'(pred_target), (h >= 0) ? 32'(m_tgt[h]) : 32'd0);
  endtask

  task automatic drive(input bit lv, input int lpc, input bit uv, input int upc,
                       input int utgt, input bit utk, input bit uptk, input int uptgt);
    lkp_valid       = lv;
    lkp_pc          = 16'(lpc);
    upd_valid       = uv;
    upd_pc          = 16'(upc);
    upd_pc_next     = 16'(upc + 1);
    upd_target      = 16'(utgt);
    upd_taken       = utk;
    upd_pred_taken  = uptk;
    upd_pred_target = 16'(uptgt);
  endtask

  // Called at a negedge after drive(): check lookup on pre-update state,
  // advance one edge, then check the registered flush outputs.
  task automatic tick(input string tag);
    int  h;
    bit  mis;
    #1;
    check_lookup(tag);
    mis = upd_valid && ((upd_taken != upd_pred_taken) ||
                        (upd_taken && upd_target != upd_pred_target));
    h = m_find(int'(upd_pc));
    @(posedge clk);
    if (upd_valid) begin
      if (h >= 0) begin
        if (upd_taken) begin
          m_ctr[h] = (m_ctr[h] < 3) ? m_ctr[h] + 1 : 3;
          m_tgt[h] = int'(upd_target);
        end else begin
          m_ctr[h] = (m_ctr[h] > 0) ? m_ctr[h] - 1 : 0;
        end
      end else if (upd_taken) begin
        m_valid[m_vp] = 1; m_tag[m_vp] = int'(upd_pc);
        m_tgt[m_vp] = int'(upd_target); m_ctr[m_vp] = 2;
        m_vp = (m_vp + 1) % N;
      end
    end
    m_flush = mis;
    if (mis) begin
      m_redir = upd_taken ? int'(upd_target) : int'(upd_pc) + 1;
      m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end
    @(negedge clk);
    check({tag, ".flush"},    32'(flush),       32'(m_flush));
    check({tag, ".redirect"}, 32'(redirect_pc), 32'(m_redir & 16'hFFFF));
    check({tag, ".cnt"},      32'(mispred_cnt), 32'(m_cnt));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int h;
    bit ptk;
    int ptgt;
    m_reset();
    do_reset();

    // Reset state.
    drive(1, 'h0010, 0, 0, 0, 0, 0, 0);
    #1;
    check("reset.hit", 32'(pred_hit), 32'd0);
    check("reset.taken", 32'(pred_taken), 32'd0);
    check("reset.flush", 32'(flush), 32'd0);
    check("reset.cnt", 32'(mispred_cnt), 32'd0);
    tick("reset");

    // First taken branch mispredicted as not-taken.
    drive(1, 'h0010, 1, 'h0010, 'h0040, 1, 0, 0);
    tick("alloc");
    check("alloc.flush_lit", 32'(flush), 32'd1);
    check("alloc.redirect_lit", 32'(redirect_pc), 32'h0040);
    drive(1, 'h0010, 0, 0, 0, 0, 0, 0);
    #1;
    check("alloc.hit_lit", 32'(pred_hit), 32'd1);
    check("alloc.taken_lit", 32'(pred_taken), 32'd1);
    check("alloc.target_lit", 32'(pred_target), 32'h0040);
    tick("alloc_lkp");

    // Three not-taken trainings: 10 -> 01 -> 00 -> 00.
    for (int k = 0; k < 3; k++) begin
      drive(1, 'h0010, 1, 'h0010, 'h0040, 0, 1, 'h0040);
      tick("nt");
      drive(1, 'h0010, 0, 0, 0, 0, 0, 0);
      #1;
      check("nt.taken_lit", 32'(pred_taken), 32'd0);
      tick("nt_lkp");
    end

    // Taken with wrong predicted target.
    drive(1, 'h0010, 1, 'h0010, 'h0050, 1, 1, 'h0040);
    tick("tgt");
    check("tgt.redirect_lit", 32'(redirect_pc), 32'h0050);
    drive(1, 'h0010, 0, 0, 0, 0, 0, 0);
    #1;
    check("tgt.target_lit", 32'(pred_target), 32'h0050);
    tick("tgt_lkp");

    // lkp_valid low suppresses the hit.
    drive(0, 'h0010, 0, 0, 0, 0, 0, 0);
    tick("lkp_off");

    // Round-robin eviction: nine allocations from a clean table.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive(0, 0, 1, 'h0100 + k, 'h0800 + k, 1, 1, 'h0800 + k);
      tick("fill");
    end
    drive(1, 'h0100, 0, 0, 0, 0, 0, 0);
    #1;
    check("evict.miss_lit", 32'(pred_hit), 32'd0);
    tick("evict");
    for (int k = 1; k < 9; k++) begin
      drive(1, 'h0100 + k, 0, 0, 0, 0, 0, 0);
      tick("evict_hit");
    end
    // vp=1 now: the next allocation must displace 0x0101.
    drive(0, 0, 1, 'h0109, 'h0900, 1, 1, 'h0900);
    tick("vp1");
    drive(1, 'h0101, 0, 0, 0, 0, 0, 0);
    #1;
    check("vp1.miss_lit", 32'(pred_hit), 32'd0);
    tick("vp1_lkp");

    // Reset while flush is high.
    drive(0, 0, 1, 'h0020, 'h0070, 1, 0, 0);
    tick("prerst");
    check("prerst.flush_lit", 32'(flush), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst.flush", 32'(flush), 32'd0);
    check("rst.redirect", 32'(redirect_pc), 32'd0);
    check("rst.cnt", 32'(mispred_cnt), 32'd0);
    m_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k < 9; k++) begin
      drive(1, 'h0100 + k, 0, 0, 0, 0, 0, 0);
      tick("postrst");
    end

    // Randomized traffic over more PCs than entries.
    for (int n = 0; n < 400; n++) begin
      int upc;
      upc = 'h0200 + int'($urandom_range(0, 11));
      h = m_find(upc);
      if ($urandom_range(0, 1) == 1) begin
        ptk  = (h >= 0) && (m_ctr[h] >= 2);
        ptgt = (h >= 0) ? m_tgt[h] : 0;
      end else begin
        ptk  = 1'($urandom_range(0, 1));
        ptgt = 'h0300 + int'($urandom_range(0, 3));
      end
      drive($urandom_range(0, 3) != 0, 'h0200 + int'($urandom_range(0, 11)),
            1'($urandom_range(0, 1)), upc, 'h0300 + int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ptk, ptgt);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
